sequencer_step_ctrl: RTL and testbench

Upstream control stage for the hex-sequence 7-segment display FSM. It turns the 50 MHz board clock into a slow one-cycle step enable. It also turns two raw, bouncing pushbuttons into a clean direction level (`modo`) and a pause/run toggle. The display FSM consumes `step` as its advance enable and `modo` as its direction select, and keeps running on `clock`.

---
 rtl/sequencer_step_ctrl_pkg.sv | 9 +
 rtl/sequencer_step_ctrl_debounce.sv | 55 +++++
 rtl/sequencer_step_ctrl.sv | 82 ++++++++
 tb/tb_sequencer_step_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sequencer_step_ctrl_pkg.sv
// Shared helpers for the step-control slice: counter width sizing.
package sequencer_step_ctrl_pkg;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sequencer_step_ctrl_debounce.sv
// Pushbutton conditioner: two-flop synchronizer, stability debounce and a
// registered one-cycle press pulse on each accepted 1->0 transition.
module button_debounce
    import sequencer_step_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_cycles_check
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic            sync1;
    logic            sync2;
    logic            stable;
    logic            stable_dly;
    logic [CntW-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            stable     <= 1'b1;
            stable_dly <= 1'b1;
            cnt        <= '0;
            press      <= 1'b0;
        end else begin
            sync1      <= btn_n;
            sync2      <= sync1;
            stable_dly <= stable;
            // Pulse one cycle after the stable level falls; releases are silent.
            press      <= stable_dly & ~stable;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CntLast) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CntW'(1);
            end
        end
    end

    assign level = stable;

endmodule

// File: rtl/sequencer_step_ctrl.sv
// Step-rate divider plus debounced mode/pause toggles feeding the display FSM.
module sequencer_step_ctrl
    import sequencer_step_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned STEP_HZ         = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_modo,
    input  logic btn_pause,
    output logic modo,
    output logic step,
    output logic paused
);

    localparam int unsigned Div = CLK_HZ / STEP_HZ;
    localparam int unsigned DivW = cnt_width(Div);
    localparam logic [DivW-1:0] DivLast = DivW'(Div - 1);

    if (Div < 2) begin : g_div_check
        $error("CLK_HZ / STEP_HZ must be at least 2");
    end

    logic modo_press;
    logic pause_press;
    logic modo_level;
    logic pause_level;
    logic unused_levels;

    assign unused_levels = modo_level ^ pause_level;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_modo (
        .clock(clock),
        .reset(reset),
        .btn_n(btn_modo),
        .level(modo_level),
        .press(modo_press)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_pause (
        .clock(clock),
        .reset(reset),
        .btn_n(btn_pause),
        .level(pause_level),
        .press(pause_press)
    );

    logic [DivW-1:0] div_cnt;
    logic [DivW-1:0] div_next;
    logic            paused_next;

    always_comb begin
        paused_next = paused ^ pause_press;
        div_next    = div_cnt;
        if (!paused) begin
            div_next = (div_cnt == DivLast) ? '0 : div_cnt + DivW'(1);
        end
    end

    // step is registered so that it is high exactly while div_cnt sits at
    // DivLast with stepping running.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            paused  <= 1'b0;
            modo    <= 1'b0;
            step    <= 1'b0;
        end else begin
            div_cnt <= div_next;
            paused  <= paused_next;
            modo    <= modo ^ modo_press;
            step    <= (div_next == DivLast) && !paused_next;
        end
    end

endmodule

// File: tb/tb_sequencer_step_ctrl.sv
// Bench for sequencer_step_ctrl: directed scenarios then random button
// activity, each cycle compared against a window-based reference model.
module tb_sequencer_step_ctrl;

    localparam int Div = 10;
    localparam int Dc  = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic btn_modo = 1'b1;
    logic btn_pause = 1'b1;
    logic modo;
    logic step;
    logic paused;

    sequencer_step_ctrl #(
        .CLK_HZ(10),
        .STEP_HZ(1),
        .DEBOUNCE_CYCLES(Dc)
    ) dut (
        .clock(clock),
        .reset(reset),
        .btn_modo(btn_modo),
        .btn_pause(btn_pause),
        .modo(modo),
        .step(step),
        .paused(paused)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Reference model state: t is the cycle index since reset release.
    int   t;
    logic hist_m[$];
    logic hist_p[$];
    logic st_m;
    logic st_p;
    int   tog_m[$];
    int   tog_p[$];
    logic modo_m;
    logic paused_m;
    int   runs;
    int   steps_seen;
    int   last_step;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    // Stable level flips at edge e when the synchronized samples of the last
    // Dc cycles all differ from it; the synchronized sample of cycle c is the
    // raw sample of cycle c-2 (released before that).
    function automatic logic window_flip(input logic h[$], input int e, input logic st);
        for (int j = 0; j < Dc; j++) begin
            int   c;
            logic samp;
            c = e - j - 2;
            samp = (c < 0) ? 1'b1 : h[c];
            if (samp == st) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        t = 0;
        hist_m.delete();
        hist_p.delete();
        tog_m.delete();
        tog_p.delete();
        st_m = 1'b1;
        st_p = 1'b1;
        modo_m = 1'b0;
        paused_m = 1'b0;
        runs = 0;
        steps_seen = 0;
        last_step = -1;
    endtask

    // Called at a negedge: checks cycle t, drives the inputs sampled at edge t,
    // advances the model, then moves to the next negedge.
    task automatic cycle(input logic bm, input logic bp);
        check("step", {31'b0, step}, {31'b0, (!paused_m && (runs % Div) == Div - 1)});
        check("modo", {31'b0, modo}, {31'b0, modo_m});
        check("paused", {31'b0, paused}, {31'b0, paused_m});
        check("div_cnt", 32'(dut.div_cnt), 32'(runs % Div));
        if (step === 1'b1) begin
            steps_seen++;
            last_step = t;
        end
        btn_modo = bm;
        btn_pause = bp;
        hist_m.push_back(bm);
        hist_p.push_back(bp);
        if (window_flip(hist_m, t, st_m)) begin
            st_m = ~st_m;
            if (!st_m) tog_m.push_back(t + 3);
        end
        if (window_flip(hist_p, t, st_p)) begin
            st_p = ~st_p;
            if (!st_p) tog_p.push_back(t + 3);
        end
        if (!paused_m) runs++;
        t++;
        while (tog_m.size() > 0 && tog_m[0] == t) begin
            void'(tog_m.pop_front());
            modo_m = ~modo_m;
        end
        while (tog_p.size() > 0 && tog_p[0] == t) begin
            void'(tog_p.pop_front());
            paused_m = ~paused_m;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1);
    endtask

    task automatic hold_modo(input logic v, input int n);
        for (int i = 0; i < n; i++) cycle(v, 1'b1);
    endtask

    task automatic hold_pause(input logic v, input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, v);
    endtask

    // Asynchronous assert away from the edge, release on a negedge.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        check("rst_modo", {31'b0, modo}, 32'd0);
        check("rst_step", {31'b0, step}, 32'd0);
        check("rst_paused", {31'b0, paused}, 32'd0);
        check("rst_div", 32'(dut.div_cnt), 32'd0);
        check("rst_deb_modo", 32'(dut.u_modo.cnt), 32'd0);
        check("rst_deb_pause", 32'(dut.u_pause.cnt), 32'd0);
        btn_modo = 1'b1;
        btn_pause = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        int run_m;
        int run_p;
        logic lv_m;
        logic lv_p;

        model_reset();
        @(negedge clock);
        do_reset();

        // Free-running steps at cycles 9, 19, 29.
        idle(35);
        check("idle_steps", 32'(steps_seen), 32'd3);
        check("idle_last_step", 32'(last_step), 32'd29);

        // Long press toggles once; second press toggles back.
        hold_modo(1'b0, 20);
        idle(10);
        check("modo_press1", {31'b0, modo}, 32'd1);
        hold_modo(1'b0, 20);
        idle(10);
        check("modo_press2", {31'b0, modo}, 32'd0);

        // Bounce pattern is rejected, clean press accepted.
        hold_modo(1'b0, 2);
        hold_modo(1'b1, 1);
        hold_modo(1'b0, 3);
        hold_modo(1'b1, 2);
        idle(10);
        check("bounce_ignored", {31'b0, modo}, 32'd0);
        hold_modo(1'b0, 6);
        idle(10);
        check("clean_press", {31'b0, modo}, 32'd1);

        // Pause lands with divider at 4, holds, then resumes.
        @(negedge clock);
        do_reset();
        idle(6);
        hold_pause(1'b0, 8);
        check("pause_rise", {31'b0, paused}, 32'd1);
        check("pause_div", 32'(dut.div_cnt), 32'd4);
        steps_seen = 0;
        idle(30);
        check("paused_no_step", 32'(steps_seen), 32'd0);
        check("paused_div_hold", 32'(dut.div_cnt), 32'd4);
        hold_pause(1'b0, 8);
        check("resume_fall", {31'b0, paused}, 32'd0);
        idle(8);
        check("resume_step_cycle", 32'(last_step), 32'd57);

        // Modo event coinciding with a step.
        @(negedge clock);
        do_reset();
        idle(12);
        hold_modo(1'b0, 7);
        check("coinc_step", {31'b0, step}, 32'd1);
        check("coinc_modo_old", {31'b0, modo}, 32'd0);
        hold_modo(1'b0, 1);
        check("coinc_modo_new", {31'b0, modo}, 32'd1);
        idle(5);

        // Reset mid-debounce and mid-divider.
        @(negedge clock);
        do_reset();
        idle(3);
        hold_modo(1'b0, 5);
        check("mid_deb_cnt", 32'(dut.u_modo.cnt), 32'd3);
        check("mid_div_cnt", 32'(dut.div_cnt), 32'd8);
        do_reset();
        idle(12);
        check("post_reset_steps", 32'(steps_seen), 32'd1);
        check("post_reset_modo", {31'b0, modo}, 32'd0);

        // Random button activity in runs of 1..8 cycles.
        run_m = 0;
        run_p = 0;
        lv_m = 1'b1;
        lv_p = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if (run_m == 0) begin
                run_m = int'($urandom_range(8, 1));
                lv_m = 1'($urandom_range(1, 0));
            end
            if (run_p == 0) begin
                run_p = int'($urandom_range(8, 1));
                lv_p = 1'($urandom_range(1, 0));
            end
            cycle(lv_m, lv_p);
            run_m--;
            run_p--;
        end
        idle(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
